cpu_sequencer: RTL and testbench

- Eight-phase instruction sequencer for the VeriRISC CPU.
- Owns the phase counter and halt state.
- Decodes the current opcode, the current phase and the ALU `zero` flag into the one-hot-ish control strobes that drive the memory, instruction register, PC, accumulator and ALU.
- Sits between the instruction register and the datapath. The ALU updates on negedge `clk`; this block advances on posedge.

---
 rtl/cpu_sequencer.sv | 122 ++++++++++++
 tb/tb_cpu_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer for the VeriRISC CPU.
// Owns the phase counter and the sticky halt flag. Decodes phase, opcode and
// the ALU zero flag into the memory, IR, PC, accumulator and ALU strobes.
module cpu_sequencer #(
  parameter int unsigned NPHASE = 8
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic                      en,
  input  logic [2:0]                opcode,
  input  logic                      zero,
  output logic [$clog2(NPHASE)-1:0] phase,
  output logic                      mem_rd,
  output logic                      load_ir,
  output logic                      halt,
  output logic                      inc_pc,
  output logic                      load_ac,
  output logic                      load_pc,
  output logic                      mem_wr
);

  // VeriRISC opcode encoding
  localparam logic [2:0] OpHlt = 3'd0;
  localparam logic [2:0] OpSkz = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpLda = 3'd5;
  localparam logic [2:0] OpSto = 3'd6;
  localparam logic [2:0] OpJmp = 3'd7;

  typedef enum logic [2:0] {
    StInstAddr  = 3'd0,
    StInstFetch = 3'd1,
    StInstLoad  = 3'd2,
    StIdle      = 3'd3,
    StOpAddr    = 3'd4,
    StOpFetch   = 3'd5,
    StAluOp     = 3'd6,
    StStore     = 3'd7
  } phase_e;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   aluop;

  assign aluop = (opcode == OpAdd) || (opcode == OpAnd) ||
                 (opcode == OpXor) || (opcode == OpLda);
  assign phase = phase_q;

  // Phase counter and halt flag registers
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      phase_q  <= StInstAddr;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Advance one phase per enabled edge; HLT leaving OP_ADDR freezes at OP_FETCH
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (en && !halted_q) begin
      phase_d = phase_e'(phase_q + 3'd1);
      if ((phase_q == StOpAddr) && (opcode == OpHlt)) begin
        halted_d = 1'b1;
      end
    end
  end

  // Strobe decode from registered phase, halt flag, opcode and zero
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        StInstAddr:  ;
        StInstFetch: mem_rd = 1'b1;
        StInstLoad,
        StIdle: begin
          mem_rd  = 1'b1;
          load_ir = 1'b1;
        end
        StOpAddr: begin
          inc_pc = 1'b1;
          halt   = (opcode == OpHlt);
        end
        StOpFetch: mem_rd = aluop;
        StAluOp: begin
          mem_rd  = aluop;
          load_ac = aluop;
          inc_pc  = (opcode == OpSkz) && zero;
          load_pc = (opcode == OpJmp);
        end
        StStore: begin
          mem_rd  = aluop;
          load_ac = aluop;
          inc_pc  = (opcode == OpJmp);
          load_pc = (opcode == OpJmp);
          mem_wr  = (opcode == OpSto);
        end
        default: ;
      endcase
    end
  end

  // Memory is single-ported: read and write must never coincide
  always_comb begin
    assert (!(mem_rd && mem_wr));
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus pushes hand-computed expected
// phase/strobe vectors; a monitor pops and compares them on the falling edge.
module tb_cpu_sequencer;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  // Per-phase expectation masks: bit i is the strobe value in phase i
  typedef struct packed {
    logic [7:0] rd;
    logic [7:0] ir;
    logic [7:0] pc;
    logic [7:0] ac;
    logic [7:0] lpc;
    logic [7:0] wr;
    logic [7:0] hlt;
  } masks_t;

  localparam masks_t M_LDA    = '{8'hEE, 8'h0C, 8'h10, 8'hC0, 8'h00, 8'h00, 8'h00};
  localparam masks_t M_STO    = '{8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h80, 8'h00};
  localparam masks_t M_SKZ1   = '{8'h0E, 8'h0C, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam masks_t M_SKZ0   = '{8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam masks_t M_JMP    = '{8'h0E, 8'h0C, 8'h90, 8'h00, 8'hC0, 8'h00, 8'h00};
  localparam masks_t M_HLT    = '{8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h10};
  localparam masks_t M_HALTED = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20};
  localparam masks_t M_ZERO   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  typedef struct {
    int         idx;
    logic [9:0] v;  // {phase, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_;
  logic       en;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;

  exp_t q[$];
  event sample_ev;
  int   tests = 0;
  int   failed = 0;
  int   nstep = 0;

  cpu_sequencer dut (
    .clk    (clk),
    .rst_   (rst_),
    .en     (en),
    .opcode (opcode),
    .zero   (zero),
    .phase  (phase),
    .mem_rd (mem_rd),
    .load_ir(load_ir),
    .halt   (halt),
    .inc_pc (inc_pc),
    .load_ac(load_ac),
    .load_pc(load_pc),
    .mem_wr (mem_wr)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation at the falling edge or on demand
  initial begin
    exp_t       e;
    logic [9:0] act;
    forever begin
      @(negedge clk or sample_ev);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = {phase, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
        tests++;
        if (act !== e.v) begin
          failed++;
          $display("FAIL step%0d: got {ph,rd,ir,hlt,pc,ac,lpc,wr}=%b want %b", e.idx, act, e.v);
        end
      end
    end
  end

  task automatic push_exp(input logic [2:0] p, input masks_t m);
    exp_t e;
    e.idx = nstep;
    e.v   = {p, m.rd[p], m.ir[p], m.hlt[p], m.pc[p], m.ac[p], m.lpc[p], m.wr[p]};
    q.push_back(e);
    nstep++;
  endtask

  // Drive inputs, expect phase p during this cycle, then move past the next edge
  task automatic step(input logic [2:0] p, input logic [2:0] op, input logic z,
                      input logic e, input masks_t m);
    opcode = op;
    zero   = z;
    en     = e;
    push_exp(p, m);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z, input masks_t m);
    for (int p = 0; p < 8; p++) step(3'(p), op, z, 1'b1, m);
  endtask

  initial begin
    rst_   = 1'b0;
    en     = 1'b1;
    opcode = LDA;
    zero   = 1'b0;
    #1;
    push_exp(3'd0, M_ZERO);
    ->sample_ev;
    @(posedge clk);
    #1;
    rst_ = 1'b1;

    run_instr(LDA, 1'b0, M_LDA);
    run_instr(LDA, 1'b1, M_LDA);
    run_instr(STO, 1'b0, M_STO);
    run_instr(SKZ, 1'b1, M_SKZ1);
    run_instr(SKZ, 1'b0, M_SKZ0);
    run_instr(JMP, 1'b0, M_JMP);
    run_instr(ADD, 1'b1, M_LDA);

    // Hold in INST_LOAD for three cycles, then resume
    step(3'd0, LDA, 1'b0, 1'b1, M_LDA);
    step(3'd1, LDA, 1'b0, 1'b1, M_LDA);
    for (int i = 0; i < 3; i++) step(3'd2, LDA, 1'b0, 1'b0, M_LDA);
    for (int p = 2; p < 8; p++) step(3'(p), LDA, 1'b0, 1'b1, M_LDA);

    // Halt: freezes at OP_FETCH with only halt asserted
    for (int p = 0; p < 5; p++) step(3'(p), HLT, 1'b0, 1'b1, M_HLT);
    for (int i = 0; i < 20; i++) step(3'd5, HLT, 1'b1, 1'b1, M_HALTED);

    // Asynchronous reset between edges clears immediately
    #2;
    rst_ = 1'b0;
    #1;
    push_exp(3'd0, M_ZERO);
    ->sample_ev;
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    run_instr(LDA, 1'b0, M_LDA);

    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
